// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer: slews PWM_DUTY toward a commanded target by bounded steps.
// Latency: first duty change on the UPD_DIV-th CE tick after accept; DONE is a registered one-cycle pulse.
// Backpressure: CMD_READY only in IDLE without ABORT; the source holds CMD_VALID while a ramp is in progress.
module pwm_ramp_ctrl #(
    parameter int UDW     = $clog2(1000000),
    parameter int UPD_DIV = 1000,
    parameter int DIVW    = $clog2(UPD_DIV + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           CMD_VALID,
    output logic           CMD_READY,
    input  logic [UDW-1:0] CMD_TARGET,
    input  logic [UDW-1:0] CMD_STEP,
    input  logic           ABORT,
    output logic [UDW-1:0] PWM_DUTY,
    output logic           BUSY,
    output logic           DONE
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

    localparam logic [DIVW-1:0] TCNT_LAST = DIVW'(UPD_DIV - 1);

    logic [0:0]     state_q, state_d;
    logic [DIVW-1:0] tcnt_q, tcnt_d;
    logic [UDW-1:0] tgt_q, tgt_d;
    logic [UDW-1:0] stp_q, stp_d;
    logic [UDW-1:0] duty_q, duty_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept;
    logic [UDW-1:0] step_nz;
    logic [UDW-1:0] diff_up;
    logic [UDW-1:0] diff_dn;

    // Ready depends only on registered state and ABORT, never on CE.
    assign CMD_READY = (state_q == S_IDLE) && !ABORT;
    assign accept    = CMD_VALID && CMD_READY;
    // A zero step would stall the ramp forever, so it is promoted to one.
    assign step_nz   = (CMD_STEP == '0) ? UDW'(1) : CMD_STEP;
    // Distances are only used in the matching direction, so neither can wrap.
    assign diff_up   = tgt_q - duty_q;
    assign diff_dn   = duty_q - tgt_q;

    // Next-state logic: ABORT overrides everything, then command accept / ramp stepping.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        duty_d  = duty_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (ABORT) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            duty_d  = '0;
            busy_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (accept) begin
                tgt_d  = CMD_TARGET;
                stp_d  = step_nz;
                tcnt_d = '0;
                if (CMD_TARGET != duty_q) begin
                    state_d = S_RAMP;
                    busy_d  = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (CE) begin
            if (tcnt_q == TCNT_LAST) begin
                tcnt_d = '0;
                if (tgt_q > duty_q) begin
                    duty_d = (diff_up <= stp_q) ? tgt_q : (duty_q + stp_q);
                end else begin
                    duty_d = (diff_dn <= stp_q) ? tgt_q : (duty_q - stp_q);
                end
                // Arrival is decided from the clamp condition so the state change lands with the final write.
                if (((tgt_q > duty_q) && (diff_up <= stp_q)) ||
                    ((tgt_q < duty_q) && (diff_dn <= stp_q)) ||
                    (tgt_q == duty_q)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                tcnt_d = tcnt_q + DIVW'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            tgt_q   <= '0;
            stp_q   <= UDW'(1);
            duty_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tgt_q   <= tgt_d;
            stp_q   <= stp_d;
            duty_q  <= duty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign PWM_DUTY = duty_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule
